spi_accel_responder: RTL and testbench
======================================

// Module: spi_accel_responder
// PURPOSE
//  Synthesizable SPI responder (slave) modelling the 3-axis accelerometer on the far end of the SPI bus.
//  Runs on sys_clock and oversamples CS/SCL/MOSI. Serves a 64x8 register file.
//  Data registers 0x32-0x37 are fed from sample ports.
//  Used in benches and on-board loopback as the counterpart of the accelerometer SPI master.
// PARAMETERS
//  SYNC_STAGES  2      flop stages on CS, SCL, MOSI before edge detection (>=2)
//  DEVID        8'hE5  reset/constant value of register 0x00
//  ADDR_W       6      register address width; register count is 2**ADDR_W
// PORTS
//  sys_clock      in   1   single clock; SCL must run at <= sys_clock/8
//  reset          in   1   synchronous, active-high
//  CS             in   1   chip select, active-low
//  SCL            in   1   SPI clock, mode 3 (idles high)
//  MOSI           in   1   master-to-responder data, MSB first
//  MISO           out  1   responder-to-master data
//  miso_oe        out  1   1 = MISO driven (read data phase only)
//  sample_x/y/z   in   16  signed axis samples, two's complement
//  sample_valid   in   1   1-cycle strobe: new sample on sample_x/y/z
//  reg_wr_strobe  out  1   1-cycle pulse on each committed register write
//  reg_wr_addr    out  6   address of committed write
//  reg_wr_data    out  8   data of committed write
//  txn_active     out  1   synchronized CS is low
// BEHAVIOUR
//  Reset: MISO=0, miso_oe=0, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, txn_active=0, FSM=IDLE.
//   Register file all 0 except 0x00=DEVID. Sync flops: CS=1, SCL=1, MOSI=0.
//  Edges are detected on synchronized signals (rise/fall = 1-cycle pulses). All actions below occur on that pulse cycle.
//  FSM IDLE -> CMD on CS fall. CMD -> DATA after the 8th SCL rise.
//   Any CS rise -> IDLE from any state; partial bytes are discarded; no write occurs.
//  CMD: MOSI is shifted in on each SCL rise.
//   Command byte: bit7 RW (1=read), bit6 MB (auto-increment), bits5:0 start address.
//  Read: on the 8th rise the shift-out register loads reg[addr]. On each SCL fall in DATA: MISO=shift[7], shift<<=1, miso_oe=1.
//   After each 8th data rise: if MB, addr=addr+1 mod 64 (0x3F wraps to 0x00); reload from the new addr.
//   If not MB, reload the same addr.
//  Write: on each 8th data rise, reg[addr]=byte.
//   In the next cycle: reg_wr_strobe=1, reg_wr_addr=addr, reg_wr_data=byte. Then addr increments if MB.
//   Read-only addresses 0x00 and 0x32-0x37: write ignored, no strobe, addr still increments.
//  MISO=0 and miso_oe=0 whenever in IDLE or CMD, or when RW=0.
//  Sample snapshot: 0x32/0x33=x[7:0]/x[15:8]; 0x34/0x35=y; 0x36/0x37=z.
//   sample_valid with txn_active=0: update the snapshot in the same cycle.
//   sample_valid with txn_active=1: hold in a pending register (latest wins); commit on CS rise.
//   Multi-byte reads are therefore coherent.
//  sample_valid coinciding with CS rise: the new sample wins over the pending one.
//  txn_active = ~synchronized CS, registered.
// STRUCTURE
//  Package accel_regs_pkg:
//   - address constants: DEVID 0x00, POWER_CTL 0x2D, DATA_FORMAT 0x31, DATAX0..DATAZ1 0x32-0x37
//   - command bit indices RW=7, MB=6
//   - FSM state encoding IDLE/CMD/DATA
//  Sub-module spi_edge_sync: SYNC_STAGES synchronizer plus rise/fall pulse generation.
//   Instantiated for CS, SCL and MOSI (MOSI uses the level output only).
//  Top level holds the FSM, bit counter (3b), shift-in/shift-out registers, address counter, register file and snapshot logic.
// TESTING
//  1. Read 0x80 (read, addr 0): MISO byte = 0xE5. miso_oe=0 during the command byte, 1 during the data byte. No strobe.
//  2. Write 0x2D then 0x08: reg_wr_strobe pulses once with addr 0x2D, data 0x08.
//     A following read 0xAD returns 0x08.
//  3. sample_x=0x1234, y=0xFF80, z=0x0001 with sample_valid while idle.
//     Read 0xF2 (read, MB, addr 0x32) for 6 bytes -> 34 12 80 FF 01 00.
//  4. During test 3's burst, pulse sample_valid with x=0xAAAA: all 6 bytes are unchanged.
//     A re-read after CS rise gives x bytes AA AA.
//  5. MB read starting at 0x3F for 2 bytes -> reg[0x3F], then 0xE5 (wrap to 0x00).
//     Write 0x00 with 0x11 -> no strobe; DEVID still 0xE5.
//  6. Abort: raise CS after 4 data bits of a write to 0x2D -> no strobe, value unchanged, FSM IDLE.
//     Assert reset mid-read -> MISO=0, miso_oe=0 the next cycle.

Source files
------------

// File: rtl/accel_regs_pkg.sv
// Register map, command-byte layout and FSM encoding shared by the accelerometer SPI responder.
package accel_regs_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam int CMD_RW = 7;
  localparam int CMD_MB = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } accel_sample_t;

  // DEVID and the sample snapshot cannot be written from the bus.
  function automatic logic is_read_only(input logic [5:0] a);
    return (a == ADDR_DEVID) || ((a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1));
  endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between the accelerometer master and this responder.
interface spi_accel_responder_if;
  logic CS;
  logic SCL;
  logic MOSI;
  logic MISO;
  logic miso_oe;

  modport master (output CS, SCL, MOSI, input MISO, miso_oe);
  modport slave  (input CS, SCL, MOSI, output MISO, miso_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with 1-cycle rise/fall pulses on the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{INIT}};
      prev_q <= INIT;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder emulating a 3-axis accelerometer register map.
// Oversamples CS/SCL/MOSI on sys_clock and serves a 2**ADDR_W x 8 register file.
module spi_accel_responder
  import accel_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         ADDR_W      = 6
) (
  input  logic                sys_clock,
  input  logic                reset,
  spi_accel_responder_if.slave spi,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  input  logic                sample_valid,
  output logic                reg_wr_strobe,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [7:0]          reg_wr_data,
  output logic                txn_active,
  output logic [1:0]          state_dbg
);
  localparam int N_REGS = 2 ** ADDR_W;

  logic cs_lvl, cs_rise, cs_fall, scl_rise, scl_fall, mosi_lvl;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clk(sys_clock), .rst(reset), .d(spi.CS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_scl_sync (
    .clk(sys_clock), .rst(reset), .d(spi.SCL), .level(), .rise(scl_rise), .fall(scl_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
    .clk(sys_clock), .rst(reset), .d(spi.MOSI), .level(mosi_lvl), .rise(), .fall());

  logic [N_REGS-1:0][7:0] regs;
  logic [1:0]             state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_in_q, shift_out_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   rw_q, mb_q;
  logic                   miso_q, miso_oe_q;
  accel_sample_t          pend_q;
  logic                   pend_valid_q;

  logic [7:0]        byte_in;
  logic              byte_done;
  logic [ADDR_W-1:0] cmd_addr, addr_next;
  logic              wr_ok;
  logic              snap_now;
  accel_sample_t     snap_data;

  assign byte_in   = {shift_in_q[6:0], mosi_lvl};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7) && !cs_rise;
  assign cmd_addr  = ADDR_W'(byte_in[5:0]);
  assign addr_next = mb_q ? addr_q + ADDR_W'(1) : addr_q;
  assign wr_ok     = (state_q == ST_DATA) && !rw_q && byte_done && !is_read_only(6'(addr_q));

  assign spi.MISO    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign state_dbg   = state_q;

  // sample_valid is a strobe with no ready: every pulse is accepted. While CS is
  // low it is parked in pend_q so a burst read sees one coherent snapshot; a
  // strobe on the CS-rise cycle itself beats whatever was pending.
  always_comb begin
    snap_now  = 1'b0;
    snap_data = {sample_x, sample_y, sample_z};
    if (sample_valid && (!txn_active || cs_rise)) begin
      snap_now = 1'b1;
    end else if (cs_rise && pend_valid_q) begin
      snap_now  = 1'b1;
      snap_data = pend_q;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      regs    <= '0;
      regs[0] <= DEVID;
    end else begin
      if (wr_ok) regs[addr_q] <= byte_in;
      if (snap_now) begin
        regs[ADDR_W'(ADDR_DATAX0)] <= snap_data.x[7:0];
        regs[ADDR_W'(ADDR_DATAX1)] <= snap_data.x[15:8];
        regs[ADDR_W'(ADDR_DATAY0)] <= snap_data.y[7:0];
        regs[ADDR_W'(ADDR_DATAY1)] <= snap_data.y[15:8];
        regs[ADDR_W'(ADDR_DATAZ0)] <= snap_data.z[7:0];
        regs[ADDR_W'(ADDR_DATAZ1)] <= snap_data.z[15:8];
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      reg_wr_data   <= '0;
      txn_active    <= 1'b0;
    end else begin
      txn_active    <= ~cs_lvl;
      reg_wr_strobe <= 1'b0;
      if (sample_valid && txn_active && !cs_rise) begin
        pend_q       <= {sample_x, sample_y, sample_z};
        pend_valid_q <= 1'b1;
      end
      if (cs_rise || (state_q != ST_DATA) || !rw_q) begin
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end
      if (cs_rise) begin
        state_q      <= ST_IDLE;
        bit_cnt_q    <= '0;
        pend_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (cs_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
          end
          ST_CMD: if (scl_rise) begin
            shift_in_q <= byte_in;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (byte_done) begin
              state_q     <= ST_DATA;
              rw_q        <= byte_in[CMD_RW];
              mb_q        <= byte_in[CMD_MB];
              addr_q      <= cmd_addr;
              shift_out_q <= regs[cmd_addr];
            end
          end
          ST_DATA: begin
            if (scl_rise) begin
              shift_in_q <= byte_in;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (byte_done) begin
                addr_q <= addr_next;
                if (rw_q) shift_out_q <= regs[addr_next];
                if (wr_ok) begin
                  reg_wr_strobe <= 1'b1;
                  reg_wr_addr   <= addr_q;
                  reg_wr_data   <= byte_in;
                end
              end
            end
            if (scl_fall && rw_q) begin
              miso_q      <= shift_out_q[7];
              miso_oe_q   <= 1'b1;
              shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_accel_responder.sv
// Bench for spi_accel_responder: directed vector table, hand sequences for the
// snapshot/abort/reset corners, then random transactions against a register-map model.
module tb_spi_accel_responder;
  import accel_regs_pkg::*;

  localparam int H = 5;  // SCL half period in sys_clock cycles

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_accel_responder_if spi_bus();
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        reg_wr_strobe;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        txn_active;
  logic [1:0]  state_dbg;

  spi_accel_responder dut (
    .sys_clock(clk), .reset(rst), .spi(spi_bus),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .reg_wr_strobe(reg_wr_strobe),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .txn_active(txn_active), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  n;
    logic [47:0] wdata;   // first data byte in [47:40]
    logic [47:0] rdata;
    logic [1:0]  n_strobe;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [7:0]  tx_bytes[$];
  logic [7:0]  rx_bytes[$];
  logic [7:0]  exp_rx[$];
  bit          cmd_oe_any, data_oe_any, data_oe_all;
  logic [7:0]  mdl[64];
  logic [15:0] pend_x, pend_y, pend_z;
  bit          pend_v;

  always @(negedge clk) if (reg_wr_strobe) obs_q.push_back({reg_wr_addr, reg_wr_data});

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    mdl[0] = 8'hE5;
    pend_v = 0;
  endtask

  task automatic model_snap(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    mdl[50] = x[7:0]; mdl[51] = x[15:8];
    mdl[52] = y[7:0]; mdl[53] = y[15:8];
    mdl[54] = z[7:0]; mdl[55] = z[15:8];
  endtask

  task automatic model_txn();
    logic [7:0] c;
    int a;
    exp_rx.delete();
    c = tx_bytes[0];
    a = int'(c[5:0]);
    for (int k = 1; k < tx_bytes.size(); k++) begin
      if (c[7]) exp_rx.push_back(mdl[a]);
      else if (!(a == 0 || (a >= 50 && a <= 55))) begin
        mdl[a] = tx_bytes[k];
        exp_q.push_back({6'(a), tx_bytes[k]});
      end
      if (c[6]) a = (a + 1) % 64;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic cs_begin();
    spi_bus.CS = 1'b0;
    tick(H);
  endtask

  task automatic cs_end();
    spi_bus.CS = 1'b1;
    tick(H + 3);
  endtask

  task automatic xfer(input logic [7:0] tx_b, input int nbits, output logic [7:0] rb,
                      output bit oe_any, output bit oe_all);
    rb = '0; oe_any = 0; oe_all = 1;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.SCL  = 1'b0;
      spi_bus.MOSI = tx_b[7-i];
      tick(H);
      rb     = {rb[6:0], spi_bus.MISO};
      oe_any = oe_any | spi_bus.miso_oe;
      oe_all = oe_all & spi_bus.miso_oe;
      spi_bus.SCL = 1'b1;
      tick(H);
    end
  endtask

  task automatic do_txn();
    logic [7:0] rb;
    bit any, all;
    rx_bytes.delete();
    cs_begin();
    xfer(tx_bytes[0], 8, rb, any, all);
    cmd_oe_any = any;
    data_oe_any = 0; data_oe_all = 1;
    for (int k = 1; k < tx_bytes.size(); k++) begin
      xfer(tx_bytes[k], 8, rb, any, all);
      rx_bytes.push_back(rb);
      data_oe_any = data_oe_any | any;
      data_oe_all = data_oe_all & all;
    end
    cs_end();
  endtask

  task automatic check_strobes(input string name);
    check({name, " strobe count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({name, " strobe"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_rx_model(input string name);
    for (int k = 0; k < exp_rx.size() && k < rx_bytes.size(); k++)
      check($sformatf("%s byte%0d", name, k), rx_bytes[k], exp_rx[k]);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[9];
  logic [7:0] rb, c, a;
  bit   any, all;
  int   n;

  initial begin
    rst = 1'b1;
    spi_bus.CS = 1'b1; spi_bus.SCL = 1'b1; spi_bus.MOSI = 1'b0;
    sample_valid = 1'b0; sample_x = '0; sample_y = '0; sample_z = '0;
    model_reset();

    vecs[0] = '{cmd: 8'h80, n: 3'd1, wdata: 48'h0, rdata: {8'hE5, 40'h0}, n_strobe: 2'd0};
    vecs[1] = '{cmd: 8'h2D, n: 3'd1, wdata: {8'h08, 40'h0}, rdata: 48'h0, n_strobe: 2'd1};
    vecs[2] = '{cmd: 8'hAD, n: 3'd1, wdata: 48'h0, rdata: {8'h08, 40'h0}, n_strobe: 2'd0};
    vecs[3] = '{cmd: 8'hF2, n: 3'd6, wdata: 48'h0, rdata: 48'h3412_80FF_0100, n_strobe: 2'd0};
    vecs[4] = '{cmd: 8'hFF, n: 3'd2, wdata: 48'h0, rdata: {16'h00E5, 32'h0}, n_strobe: 2'd0};
    vecs[5] = '{cmd: 8'h00, n: 3'd1, wdata: {8'h11, 40'h0}, rdata: 48'h0, n_strobe: 2'd0};
    vecs[6] = '{cmd: 8'h80, n: 3'd1, wdata: 48'h0, rdata: {8'hE5, 40'h0}, n_strobe: 2'd0};
    vecs[7] = '{cmd: 8'h71, n: 3'd2, wdata: {16'h0B77, 32'h0}, rdata: 48'h0, n_strobe: 2'd1};
    vecs[8] = '{cmd: 8'hF1, n: 3'd2, wdata: 48'h0, rdata: {16'h0B34, 32'h0}, n_strobe: 2'd0};

    tick(4);
    check("reset MISO", spi_bus.MISO, 0);
    check("reset miso_oe", spi_bus.miso_oe, 0);
    check("reset strobe", reg_wr_strobe, 0);
    check("reset wr_addr", reg_wr_addr, 0);
    check("reset wr_data", reg_wr_data, 0);
    check("reset txn_active", txn_active, 0);
    check("reset state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick(3);

    pulse_sample(16'h1234, 16'hFF80, 16'h0001);
    model_snap(16'h1234, 16'hFF80, 16'h0001);
    tick(2);

    for (int v = 0; v < 9; v++) begin
      tx_bytes.delete();
      tx_bytes.push_back(vecs[v].cmd);
      for (int k = 0; k < int'(vecs[v].n); k++) tx_bytes.push_back(vecs[v].wdata[47-8*k -: 8]);
      model_txn();
      do_txn();
      c = vecs[v].cmd;
      check($sformatf("vec%0d cmd oe", v), cmd_oe_any, 0);
      if (c[7]) begin
        check($sformatf("vec%0d data oe", v), data_oe_all, 1);
        for (int k = 0; k < int'(vecs[v].n); k++)
          check($sformatf("vec%0d rd%0d", v, k), rx_bytes[k], vecs[v].rdata[47-8*k -: 8]);
      end else begin
        check($sformatf("vec%0d write oe", v), data_oe_any, 0);
      end
      check($sformatf("vec%0d n_strobe", v), obs_q.size(), int'(vecs[v].n_strobe));
      check_strobes($sformatf("vec%0d", v));
    end

    // Burst read with a new sample arriving mid-burst: bytes stay coherent.
    tx_bytes = '{8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn();
    rx_bytes.delete();
    cs_begin();
    check("txn_active in burst", txn_active, 1);
    xfer(8'hF2, 8, rb, any, all);
    for (int k = 1; k < 7; k++) begin
      xfer(8'h00, 8, rb, any, all);
      rx_bytes.push_back(rb);
      if (k == 1) begin
        pulse_sample(16'hAAAA, 16'hFF80, 16'h0001);
        pend_x = 16'hAAAA; pend_y = 16'hFF80; pend_z = 16'h0001; pend_v = 1;
      end
    end
    cs_end();
    if (pend_v) model_snap(pend_x, pend_y, pend_z);
    pend_v = 0;
    check_rx_model("coherent burst");
    check("coherent x0", rx_bytes[0], 8'h34);
    tx_bytes = '{8'hF2, 8'h00, 8'h00};
    model_txn(); do_txn();
    check("reread x0", rx_bytes[0], 8'hAA);
    check("reread x1", rx_bytes[1], 8'hAA);
    check_strobes("burst");

    // Strobe landing on the synchronized CS rise wins over the pending sample.
    tx_bytes = '{8'hB4, 8'h00};
    model_txn();
    rx_bytes.delete();
    cs_begin();
    xfer(8'hB4, 8, rb, any, all);
    xfer(8'h00, 8, rb, any, all);
    rx_bytes.push_back(rb);
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    spi_bus.CS = 1'b1;
    tick(2);
    pulse_sample(16'h5555, 16'h6666, 16'h7777);
    tick(H + 3);
    model_snap(16'h5555, 16'h6666, 16'h7777);
    check_rx_model("pre-rise read");
    tx_bytes = '{8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_txn(); do_txn();
    check_rx_model("new wins");
    check("new wins y0", rx_bytes[2], 8'h66);
    check_strobes("coincide");

    // Abort a write after 4 data bits.
    cs_begin();
    xfer(8'h2D, 8, rb, any, all);
    xfer(8'h55, 4, rb, any, all);
    cs_end();
    check("abort state", state_dbg, ST_IDLE);
    check("abort txn_active", txn_active, 0);
    check_strobes("abort");
    tx_bytes = '{8'hAD, 8'h00};
    model_txn(); do_txn();
    check("abort keeps value", rx_bytes[0], 8'h08);

    // Randomized transactions against the model.
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        0:       a = 8'h00;
        1:       a = 8'h2D;
        2:       a = 8'($urandom_range(8'h30, 8'h38));
        3:       a = 8'h3F;
        default: a = 8'($urandom_range(0, 63));
      endcase
      c = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a[5:0]};
      n = $urandom_range(1, 4);
      tx_bytes.delete();
      tx_bytes.push_back(c);
      for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      model_txn();
      do_txn();
      check($sformatf("rnd%0d cmd oe", t), cmd_oe_any, 0);
      if (c[7]) begin
        check($sformatf("rnd%0d data oe", t), data_oe_all, 1);
        check_rx_model($sformatf("rnd%0d", t));
      end else begin
        check($sformatf("rnd%0d write oe", t), data_oe_any, 0);
      end
      check_strobes($sformatf("rnd%0d", t));
      if ($urandom_range(0, 2) == 0) begin
        pend_x = 16'($urandom); pend_y = 16'($urandom); pend_z = 16'($urandom);
        pulse_sample(pend_x, pend_y, pend_z);
        model_snap(pend_x, pend_y, pend_z);
        tick(2);
      end
    end

    // Reset in the middle of a read data byte.
    cs_begin();
    xfer(8'h80, 8, rb, any, all);
    xfer(8'h00, 4, rb, any, all);
    check("pre-reset oe", spi_bus.miso_oe, 1);
    rst = 1'b1;
    tick(1);
    check("mid-read reset MISO", spi_bus.MISO, 0);
    check("mid-read reset oe", spi_bus.miso_oe, 0);
    check("mid-read reset state", state_dbg, ST_IDLE);
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(2);
    cs_end();
    obs_q.delete();
    tx_bytes = '{8'hAD, 8'h00};
    model_txn(); do_txn();
    check("post-reset power_ctl", rx_bytes[0], 8'h00);
    tx_bytes = '{8'h80, 8'h00};
    model_txn(); do_txn();
    check("post-reset devid", rx_bytes[0], 8'hE5);
    check_strobes("post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
